// File: rtl/conv2_ctrl_pkg.sv
// conv2_ctrl_pkg: shared constants, state encoding and small structs for the
// conv2 layer sequencer.
package conv2_ctrl_pkg;

  // Layer geometry and datapath latencies (defaults for the top parameters).
  localparam int C2_IN_DIM   = 14;
  localparam int C2_K        = 5;
  localparam int C2_OUT_DIM  = 10;
  localparam int C2_RD_LAT   = 1;
  localparam int C2_MAC_LAT  = 1;
  localparam int C2_EXEC_LAT = 2;

  // Derived widths.
  localparam int F3_AW  = 8;  // f3 address, 0..195
  localparam int F4_AW  = 7;  // f4 address, 0..99
  localparam int TAP_W  = 5;  // kernel tap, 0..24
  localparam int POS_W  = 4;  // output row/col counter
  localparam int KOFF_W = 3;  // ky/kx counter

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // MAC strobes travelling through the read-latency delay.
  typedef struct packed {
    logic en;
    logic first;
  } mac_strb_t;

  // Per-pixel write token travelling through the full result latency.
  typedef struct packed {
    logic             vld;
    logic [F4_AW-1:0] addr;
  } wr_tok_t;

  // Cycles from the last tap issue of a pixel to its f4 write.
  function automatic int wr_lat(input int rd_lat, input int mac_lat, input int exec_lat);
    return rd_lat + mac_lat + exec_lat;
  endfunction

endpackage

// File: rtl/conv2_ctrl_if.sv
// conv2_ctrl_if: control bundle between the conv2 sequencer and the datapath.
//   start      : one-cycle run request (into the sequencer)
//   busy/done  : layer status, done pulses once after the final f4 write
//   f3_rd/f3_raddr/w_tap : feature-map read and matching weight tap
//   mac_en/mac_first     : accumulate strobes aligned with f3 read data
//   f4_we/f4_waddr       : output-plane write
// master = sequencer side, slave = datapath / requester side.
interface conv2_ctrl_if;
  logic                              start;
  logic                              busy;
  logic                              done;
  logic                              f3_rd;
  logic [conv2_ctrl_pkg::F3_AW-1:0]  f3_raddr;
  logic [conv2_ctrl_pkg::TAP_W-1:0]  w_tap;
  logic                              mac_en;
  logic                              mac_first;
  logic                              f4_we;
  logic [conv2_ctrl_pkg::F4_AW-1:0]  f4_waddr;

  modport master (
    input  start,
    output busy, done, f3_rd, f3_raddr, w_tap, mac_en, mac_first, f4_we, f4_waddr
  );

  modport slave (
    output start,
    input  busy, done, f3_rd, f3_raddr, w_tap, mac_en, mac_first, f4_we, f4_waddr
  );
endinterface

// File: rtl/conv2_ctrl_delay_line.sv
// ctrl_delay_line: WIDTH-bit shift register, DEPTH stages (DEPTH >= 1).
//   clk : rising-edge clock
//   clr : synchronous active-high clear of every stage
//   d   : input, appears on q exactly DEPTH cycles later
//   q   : delayed output
module ctrl_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (clr) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/conv2_ctrl.sv
// conv2_ctrl: sequencer for the second convolution layer.
// Walks row/col over the output plane and ky/kx over the kernel, one tap per
// cycle, drives the f3 read / weight tap / MAC strobes, and delays a per-pixel
// token through the MAC + execute pipeline to produce the f4 write.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, asserted HIGH despite the name
//   bus   : conv2_ctrl_if master (start in; status, read, MAC, write out)
module conv2_ctrl
  import conv2_ctrl_pkg::*;
#(
  parameter int IN_DIM   = C2_IN_DIM,
  parameter int K        = C2_K,
  parameter int OUT_DIM  = C2_OUT_DIM,
  parameter int RD_LAT   = C2_RD_LAT,
  parameter int MAC_LAT  = C2_MAC_LAT,
  parameter int EXEC_LAT = C2_EXEC_LAT
) (
  input  logic          clk,
  input  logic          rst_n,
  conv2_ctrl_if.master  bus
);
  localparam int LAT = wr_lat(RD_LAT, MAC_LAT, EXEC_LAT);

  localparam logic [KOFF_W-1:0] K_LAST   = KOFF_W'(K - 1);
  localparam logic [POS_W-1:0]  O_LAST   = POS_W'(OUT_DIM - 1);
  localparam logic [F3_AW-1:0]  IN_DIM_A = F3_AW'(IN_DIM);
  localparam logic [F4_AW-1:0]  OUT_DIM_A = F4_AW'(OUT_DIM);
  localparam logic [TAP_W-1:0]  K_T      = TAP_W'(K);
  localparam logic [TAP_W-1:0]  TAP_LAST = TAP_W'(K * K - 1);
  localparam logic [F4_AW-1:0]  PIX_LAST = F4_AW'(OUT_DIM * OUT_DIM - 1);

  state_t             state;
  logic [POS_W-1:0]   row, col, row_n, col_n;
  logic [KOFF_W-1:0]  ky, kx, ky_n, kx_n;
  logic               last_tap;
  logic               busy_r, done_r, f3_rd_r;
  logic [F3_AW-1:0]   f3_raddr_r;
  logic [TAP_W-1:0]   w_tap_r;

  mac_strb_t          mac_in, mac_q;
  wr_tok_t            wr_in, wr_q;

  function automatic logic [F3_AW-1:0] f3_addr(input logic [POS_W-1:0] r, c,
                                                input logic [KOFF_W-1:0] y, x);
    return (F3_AW'(r) + F3_AW'(y)) * IN_DIM_A + F3_AW'(c) + F3_AW'(x);
  endfunction

  function automatic logic [TAP_W-1:0] tap_idx(input logic [KOFF_W-1:0] y, x);
    return TAP_W'(y) * K_T + TAP_W'(x);
  endfunction

  // Next tap in the row/col/ky/kx nest. Only consumed when last_tap is low,
  // so the row increment past the final row is never used.
  always_comb begin
    row_n    = row;
    col_n    = col;
    ky_n     = ky;
    kx_n     = kx;
    last_tap = (row == O_LAST) && (col == O_LAST) && (ky == K_LAST) && (kx == K_LAST);
    if (kx != K_LAST) begin
      kx_n = kx + KOFF_W'(1);
    end else begin
      kx_n = '0;
      if (ky != K_LAST) begin
        ky_n = ky + KOFF_W'(1);
      end else begin
        ky_n = '0;
        if (col != O_LAST) begin
          col_n = col + POS_W'(1);
        end else begin
          col_n = '0;
          row_n = row + POS_W'(1);
        end
      end
    end
  end

  // Counters always describe the tap currently on f3_raddr/w_tap.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      ky         <= '0;
      kx         <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      f3_rd_r    <= 1'b0;
      f3_raddr_r <= '0;
      w_tap_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state      <= RUN;
            busy_r     <= 1'b1;
            f3_rd_r    <= 1'b1;
            row        <= '0;
            col        <= '0;
            ky         <= '0;
            kx         <= '0;
            f3_raddr_r <= '0;
            w_tap_r    <= '0;
          end
        end
        RUN: begin
          if (last_tap) begin
            state      <= DRAIN;
            f3_rd_r    <= 1'b0;
            row        <= '0;
            col        <= '0;
            ky         <= '0;
            kx         <= '0;
            f3_raddr_r <= '0;
            w_tap_r    <= '0;
          end else begin
            row        <= row_n;
            col        <= col_n;
            ky         <= ky_n;
            kx         <= kx_n;
            f3_raddr_r <= f3_addr(row_n, col_n, ky_n, kx_n);
            w_tap_r    <= tap_idx(ky_n, kx_n);
          end
        end
        DRAIN: begin
          // Leave as the last pixel's write is on the bus this cycle.
          if (wr_q.vld && (wr_q.addr == PIX_LAST)) begin
            state  <= FIN;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        FIN: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MAC strobes follow the read by the memory latency.
  assign mac_in.en    = f3_rd_r;
  assign mac_in.first = f3_rd_r && (w_tap_r == '0);

  ctrl_delay_line #(.WIDTH($bits(mac_strb_t)), .DEPTH(RD_LAT)) u_mac_dly (
    .clk (clk),
    .clr (rst_n),
    .d   (mac_in),
    .q   (mac_q)
  );

  // Token is tagged on the last tap; address zeroed otherwise so f4_waddr idles at 0.
  assign wr_in.vld  = f3_rd_r && (w_tap_r == TAP_LAST);
  assign wr_in.addr = wr_in.vld ? (F4_AW'(row) * OUT_DIM_A + F4_AW'(col)) : '0;

  ctrl_delay_line #(.WIDTH($bits(wr_tok_t)), .DEPTH(LAT)) u_wr_dly (
    .clk (clk),
    .clr (rst_n),
    .d   (wr_in),
    .q   (wr_q)
  );

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.f3_rd     = f3_rd_r;
  assign bus.f3_raddr  = f3_raddr_r;
  assign bus.w_tap     = w_tap_r;
  assign bus.mac_en    = mac_q.en;
  assign bus.mac_first = mac_q.first;
  assign bus.f4_we     = wr_q.vld;
  assign bus.f4_waddr  = wr_q.addr;
endmodule
